// File: rtl/decoder_pkg.sv
// Shared definitions for the handshaked one-hot decoder: mode encodings,
// FSM state enum and a small elaboration-time helper.
// No ports; imported by decoder_seq.
package decoder_pkg;

  localparam logic [1:0] MODE_PULSE = 2'b00;
  localparam logic [1:0] MODE_LATCH = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_SCAN  = 2'd3
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational BITS->SIZE binary-to-one-hot decoder; all-zero when the
// index is SIZE or above.
// Ports: idx_i (binary index), dec_o (one-hot result).
module onehot_dec #(
  parameter int BITS = 2,
  parameter int SIZE = 4
) (
  input  logic [BITS-1:0] idx_i,
  output logic [SIZE-1:0] dec_o
);

  always_comb begin
    dec_o = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (int'(idx_i) == i) dec_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered, valid/ready handshaked one-hot decoder with PULSE, LATCH,
// SCAN and CLEAR modes; out-of-range indices raise a one-cycle err.
// Ports: clk, rst_n, in_valid/in_ready/in/mode (request side),
//        out/out_valid (select vector), busy, err (status). Latency 1 cycle.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int BITS      = 2,
  parameter int SIZE      = 4,
  parameter int PULSE_LEN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in,
  input  logic [1:0]      mode,
  output logic [SIZE-1:0] out,
  output logic            out_valid,
  output logic            busy,
  output logic            err
);

  localparam int CNT_MAX = max_int(PULSE_LEN, SIZE);
  localparam int CW      = $clog2(CNT_MAX + 1);

  // Counter holds "remaining steps after the current one", so it is loaded
  // with length-1 and the state exits on the edge where it reads zero.
  localparam logic [CW-1:0]   PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0]   SCAN_LOAD  = CW'(SIZE - 1);
  localparam logic [BITS-1:0] IDX_LAST   = BITS'(SIZE - 1);
  // One extra bit so SIZE == 2**BITS is representable.
  localparam logic [BITS:0]   SIZE_W     = (BITS + 1)'(SIZE);

  state_e          state_q, state_d;
  logic [BITS-1:0] idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            en_q, en_d;
  logic            err_q, err_d;

  logic            accept;
  logic            in_range;
  logic [BITS-1:0] idx_inc;
  logic [SIZE-1:0] dec;

  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_HOLD);
  assign accept   = in_valid && in_ready;
  assign in_range = ({1'b0, in} < SIZE_W);

  // Explicit wrap at SIZE-1 keeps the scan inside range for non-power-of-2 SIZE.
  assign idx_inc = (idx_q == IDX_LAST) ? '0 : idx_q + BITS'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    err_d   = 1'b0;

    if (accept) begin
      if (!in_range) begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        err_d   = 1'b1;
      end else begin
        case (mode)
          MODE_PULSE: begin
            state_d = ST_PULSE;
            idx_d   = in;
            cnt_d   = PULSE_LOAD;
            en_d    = 1'b1;
          end
          MODE_LATCH: begin
            state_d = ST_HOLD;
            idx_d   = in;
            en_d    = 1'b1;
          end
          MODE_SCAN: begin
            state_d = ST_SCAN;
            idx_d   = in;
            cnt_d   = SCAN_LOAD;
            en_d    = 1'b1;
          end
          default: begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
          end
        endcase
      end
    end else begin
      case (state_q)
        ST_PULSE: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_SCAN: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - CW'(1);
            idx_d = idx_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      err_q   <= err_d;
    end
  end

  onehot_dec #(
    .BITS (BITS),
    .SIZE (SIZE)
  ) u_dec (
    .idx_i (idx_q),
    .dec_o (dec)
  );

  // idx_q only ever holds in-range values while en_q is set, so en_q
  // is exactly |out and serves directly as out_valid.
  assign out       = dec & {SIZE{en_q}};
  assign out_valid = en_q;
  assign busy      = (state_q == ST_PULSE) || (state_q == ST_SCAN);
  assign err       = err_q;

endmodule
